// File: rtl/ps2_mouse_command_tx_if.sv
// rtl/ps2_mouse_command_tx_if.sv - control/pin bundle for the PS/2 mouse command transmitter
// Purpose: groups the request handshake, raw PS/2 pin inputs and open-drain drive/status outputs.
// Signals:
//   iStart, iEnable       request level and command select from the control FSM
//   iPs2Clk, iPs2Dat      raw (asynchronous) PS2_CLK / PS2_DAT pin levels
//   oPs2ClkLow, oPs2DatLow  1 = pull the corresponding pin low
//   oBusy, oDone, oError  status level and 1-cycle result pulses
// Modports: master = request side / pin model, slave = transmitter.
interface ps2_mouse_command_tx_if;
    logic iStart;
    logic iEnable;
    logic iPs2Clk;
    logic iPs2Dat;
    logic oPs2ClkLow;
    logic oPs2DatLow;
    logic oBusy;
    logic oDone;
    logic oError;

    modport master (
        output iStart, iEnable, iPs2Clk, iPs2Dat,
        input  oPs2ClkLow, oPs2DatLow, oBusy, oDone, oError
    );

    modport slave (
        input  iStart, iEnable, iPs2Clk, iPs2Dat,
        output oPs2ClkLow, oPs2DatLow, oBusy, oDone, oError
    );
endinterface

// File: rtl/ps2_mouse_command_tx.sv
// rtl/ps2_mouse_command_tx.sv - PS/2 host-to-device sender for mouse enable/disable commands
// Purpose: on a rising edge of iStart sends 0xF4 (iEnable=1) or 0xF5 (iEnable=0) to the mouse:
//   clock inhibit, request-to-send, 8 data bits LSB first, odd parity, stop, then checks the
//   device ACK bit. One request arriving while busy is remembered (last one wins).
// Ports:
//   iClk     system clock (single domain)
//   iResetn  asynchronous active-low reset; releases both PS/2 lines at once
//   bus      slave modport of ps2_mouse_command_tx_if (request, raw pins, drive, status)
module ps2_mouse_command_tx #(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic                         iClk,
    input  logic                         iResetn,
    ps2_mouse_command_tx_if.slave        bus
);
    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]  CMD_ENABLE  = 8'hF4;
    localparam logic [7:0]  CMD_DISABLE = 8'hF5;

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_WAIT_ACK, S_DONE, S_ERR
    } state_e;

    state_e            state_q, state_d;
    logic              clk_s1_q, clk_sync_q, clk_prev_q;
    logic              dat_s1_q, dat_sync_q;
    logic              start_q;
    logic              pend_q, pend_d;
    logic [7:0]        pend_cmd_q, pend_cmd_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0]  inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              clk_low_q, clk_low_d;
    logic              dat_low_q, dat_low_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              fall;
    logic              trigger;
    logic [7:0]        req_cmd;
    logic [3:0]        next_bit;

    assign fall     = clk_prev_q & ~clk_sync_q;
    assign trigger  = bus.iStart & ~start_q;
    assign req_cmd  = bus.iEnable ? CMD_ENABLE : CMD_DISABLE;
    assign next_bit = bit_cnt_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_cmd_d = pend_cmd_q;
        cmd_d      = cmd_q;
        bit_cnt_d  = bit_cnt_q;
        inh_cnt_d  = inh_cnt_q;
        to_cnt_d   = to_cnt_q;
        dat_low_d  = dat_low_q;

        // A request seen mid-transfer is parked; IDLE consumes it.
        if (trigger && (state_q != S_IDLE)) begin
            pend_d     = 1'b1;
            pend_cmd_d = req_cmd;
        end

        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    cmd_d     = req_cmd;
                    pend_d    = 1'b0;
                    inh_cnt_d = '0;
                    state_d   = S_INHIBIT;
                end else if (pend_q) begin
                    cmd_d     = pend_cmd_q;
                    pend_d    = 1'b0;
                    inh_cnt_d = '0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                    state_d   = S_REQ;
                    bit_cnt_d = '0;
                    to_cnt_d  = '0;
                    dat_low_d = 1'b1;   // start bit
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            S_REQ, S_SEND, S_WAIT_ACK: begin
                if (fall) begin
                    to_cnt_d = '0;
                    case (state_q)
                        S_REQ: begin
                            dat_low_d = ~cmd_q[0];
                            bit_cnt_d = '0;
                            state_d   = S_SEND;
                        end
                        S_SEND: begin
                            // Index 8 is parity; the fall after it releases the line
                            // for the stop bit and the 11th fall carries the ACK.
                            if (bit_cnt_q == 4'd8) begin
                                bit_cnt_d = 4'd9;
                                state_d   = S_WAIT_ACK;
                            end else begin
                                bit_cnt_d = next_bit;
                                dat_low_d = (next_bit == 4'd8) ? (^cmd_q)
                                                               : ~cmd_q[next_bit[2:0]];
                            end
                        end
                        default: begin
                            state_d = dat_sync_q ? S_ERR : S_DONE;
                        end
                    endcase
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_ERR;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if ((state_d != S_REQ) && (state_d != S_SEND)) begin
            dat_low_d = 1'b0;
        end
        clk_low_d = (state_d == S_INHIBIT);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        err_d     = (state_d == S_ERR);
    end

    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            state_q    <= S_IDLE;
            clk_s1_q   <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_sync_q <= 1'b1;
            start_q    <= 1'b0;
            pend_q     <= 1'b0;
            pend_cmd_q <= '0;
            cmd_q      <= '0;
            bit_cnt_q  <= '0;
            inh_cnt_q  <= '0;
            to_cnt_q   <= '0;
            clk_low_q  <= 1'b0;
            dat_low_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_s1_q   <= bus.iPs2Clk;
            clk_sync_q <= clk_s1_q;
            clk_prev_q <= clk_sync_q;
            dat_s1_q   <= bus.iPs2Dat;
            dat_sync_q <= dat_s1_q;
            start_q    <= bus.iStart;
            pend_q     <= pend_d;
            pend_cmd_q <= pend_cmd_d;
            cmd_q      <= cmd_d;
            bit_cnt_q  <= bit_cnt_d;
            inh_cnt_q  <= inh_cnt_d;
            to_cnt_q   <= to_cnt_d;
            clk_low_q  <= clk_low_d;
            dat_low_q  <= dat_low_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.oPs2ClkLow = clk_low_q;
    assign bus.oPs2DatLow = dat_low_q;
    assign bus.oBusy      = busy_q;
    assign bus.oDone      = done_q;
    assign bus.oError     = err_q;
endmodule

// File: tb/tb_ps2_mouse_command_tx.sv
// tb/tb_ps2_mouse_command_tx.sv - self-checking bench for ps2_mouse_command_tx
`timescale 1ns/1ps
module tb_ps2_mouse_command_tx;
    localparam int INH  = 10;
    localparam int TOUT = 200;
    localparam int HALF = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ps2_mouse_command_tx_if bus();

    ps2_mouse_command_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .iClk    (clk),
        .iResetn (rst_n),
        .bus     (bus)
    );

    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    assign bus.iPs2Clk = ~(bus.oPs2ClkLow | dev_clk_low);
    assign bus.iPs2Dat = ~(bus.oPs2DatLow | dev_dat_low);

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
    } frame_t;

    typedef struct {
        logic       en;
        int         hold;
        logic       ack;
        logic [7:0] cmd;
        logic       par;
        int         exp_done;
        int         exp_err;
    } vec_t;

    frame_t exp_q[$];
    frame_t obs_q[$];
    vec_t   vecs[4];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Monitors
    int done_cnt = 0, err_cnt = 0, overlap_cnt = 0, inh_run = 0, last_inh = 0;
    always @(negedge clk) begin
        if (bus.oDone)  done_cnt <= done_cnt + 1;
        if (bus.oError) err_cnt  <= err_cnt + 1;
        if (bus.oPs2ClkLow && bus.oPs2DatLow) overlap_cnt <= overlap_cnt + 1;
        if (bus.oPs2ClkLow) inh_run <= inh_run + 1;
        else if (inh_run > 0) begin
            last_inh <= inh_run;
            inh_run  <= 0;
        end
    end

    // Device model: answers a request-to-send with 11 clock falls, samples host bits
    // on each rising edge and drives ACK low (if dev_ack) before the 11th fall.
    logic       dev_silent = 1'b0;
    logic       dev_ack    = 1'b1;
    logic       dev_active = 1'b0;
    int         dev_falls  = 0;
    logic [9:0] dev_bits;
    frame_t     dev_frame;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.oPs2DatLow && !bus.oPs2ClkLow && !dev_silent) begin
                dev_active = 1'b1;
                dev_falls  = 0;
                dev_bits   = '0;
                repeat (HALF) @(negedge clk);
                for (int i = 0; i < 11; i++) begin
                    if (i == 10) dev_dat_low = dev_ack;
                    dev_clk_low = 1'b1;
                    dev_falls   = i + 1;
                    repeat (HALF) @(negedge clk);
                    dev_clk_low = 1'b0;
                    dev_dat_low = 1'b0;
                    if (i < 10) dev_bits[i] = bus.iPs2Dat;
                    repeat (HALF) @(negedge clk);
                end
                dev_frame.data = dev_bits[7:0];
                dev_frame.par  = dev_bits[8];
                dev_frame.stop = dev_bits[9];
                obs_q.push_back(dev_frame);
                dev_active = 1'b0;
            end
        end
    end

    task automatic push_exp(input logic [7:0] cmd, input logic par);
        frame_t e;
        e.data = cmd;
        e.par  = par;
        e.stop = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic check_frame(input string name);
        frame_t e, o;
        if (exp_q.size() == 0 || obs_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: frame missing (observed %0d expected %0d)", name, obs_q.size(), exp_q.size());
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({name, "_data"},   32'(o.data), 32'(e.data));
            chk({name, "_parity"}, 32'(o.par),  32'(e.par));
            chk({name, "_stop"},   32'(o.stop), 32'(e.stop));
        end
    endtask

    task automatic wait_busy(input logic val, input int budget, input string name);
        int n = 0;
        while (bus.oBusy !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus.oBusy !== val) timeout_fail(name);
    endtask

    task automatic wait_dev_idle(input int budget, input string name);
        int n = 0;
        while (dev_active && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (dev_active) timeout_fail(name);
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.oDone && n < budget);
        if (!bus.oDone) timeout_fail(name);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int base_done, base_err, gap, t;

    initial begin
        vecs[0] = '{1'b1, 1,  1'b1, 8'hF4, 1'b0, 1, 0};
        vecs[1] = '{1'b0, 50, 1'b1, 8'hF5, 1'b1, 1, 0};
        vecs[2] = '{1'b1, 3,  1'b0, 8'hF4, 1'b0, 0, 1};
        vecs[3] = '{1'b0, 1,  1'b1, 8'hF5, 1'b1, 1, 0};

        bus.iStart  = 1'b0;
        bus.iEnable = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_clk_low", 32'(bus.oPs2ClkLow), 0);
        chk("reset_dat_low", 32'(bus.oPs2DatLow), 0);
        chk("reset_busy",    32'(bus.oBusy), 0);
        chk("reset_done",    32'(bus.oDone), 0);
        chk("reset_error",   32'(bus.oError), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Table-driven single frames
        foreach (vecs[k]) begin
            dev_ack   = vecs[k].ack;
            base_done = done_cnt;
            base_err  = err_cnt;
            @(negedge clk);
            bus.iEnable = vecs[k].en;
            bus.iStart  = 1'b1;
            push_exp(vecs[k].cmd, vecs[k].par);
            repeat (vecs[k].hold) @(negedge clk);
            bus.iStart = 1'b0;
            wait_busy(1'b0, 3000, $sformatf("vec%0d_busy_drop", k));
            wait_dev_idle(500, $sformatf("vec%0d_dev_idle", k));
            repeat (100) @(negedge clk);
            check_frame($sformatf("vec%0d", k));
            chk($sformatf("vec%0d_done_count", k),  32'(done_cnt - base_done), 32'(vecs[k].exp_done));
            chk($sformatf("vec%0d_error_count", k), 32'(err_cnt - base_err),   32'(vecs[k].exp_err));
            chk($sformatf("vec%0d_inhibit_len", k), 32'(last_inh), INH);
            chk($sformatf("vec%0d_idle_busy", k),   32'(bus.oBusy), 0);
        end

        // Request while busy: F5 then parked F4 starting right after IDLE
        dev_ack   = 1'b1;
        base_done = done_cnt;
        base_err  = err_cnt;
        bus.iEnable = 1'b0;
        bus.iStart  = 1'b1;
        push_exp(8'hF5, 1'b1);
        @(negedge clk);
        bus.iStart = 1'b0;
        repeat (300) @(negedge clk);
        bus.iEnable = 1'b1;
        bus.iStart  = 1'b1;
        push_exp(8'hF4, 1'b0);
        @(negedge clk);
        bus.iStart  = 1'b0;
        bus.iEnable = 1'b0;
        wait_done(3000, "pend_first_done");
        gap = 0;
        while (!bus.oPs2ClkLow && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        chk("pend_restart_gap", 32'(gap), 2);
        wait_done(3000, "pend_second_done");
        wait_dev_idle(500, "pend_dev_idle");
        repeat (50) @(negedge clk);
        check_frame("pend_f5");
        check_frame("pend_f4");
        chk("pend_done_count",  32'(done_cnt - base_done), 2);
        chk("pend_error_count", 32'(err_cnt - base_err), 0);

        // Silent device: timeout measured from REQ entry
        dev_silent = 1'b1;
        base_done  = done_cnt;
        bus.iEnable = 1'b1;
        bus.iStart  = 1'b1;
        @(negedge clk);
        bus.iStart = 1'b0;
        t = 0;
        while (!bus.oPs2DatLow && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus.oPs2DatLow) timeout_fail("timeout_req_seen");
        t = 0;
        while (!bus.oError && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("timeout_cycle",   32'(t), TOUT);
        chk("timeout_clk_rel", 32'(bus.oPs2ClkLow), 0);
        chk("timeout_dat_rel", 32'(bus.oPs2DatLow), 0);
        repeat (20) @(negedge clk);
        chk("timeout_no_done", 32'(done_cnt - base_done), 0);
        dev_silent = 1'b0;

        // Asynchronous reset mid-frame
        dev_ack = 1'b1;
        bus.iEnable = 1'b1;
        bus.iStart  = 1'b1;
        @(negedge clk);
        bus.iStart = 1'b0;
        t = 0;
        while (!(dev_falls >= 2 && bus.oPs2DatLow) && t < 1500) begin
            @(negedge clk);
            t++;
        end
        if (!(dev_falls >= 2 && bus.oPs2DatLow)) timeout_fail("rst_reach_send");
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_clk_low", 32'(bus.oPs2ClkLow), 0);
        chk("rst_dat_low", 32'(bus.oPs2DatLow), 0);
        chk("rst_busy",    32'(bus.oBusy), 0);
        wait_dev_idle(1500, "rst_dev_idle");
        obs_q.delete();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        base_done = done_cnt;
        base_err  = err_cnt;
        repeat (300) @(negedge clk);
        chk("rst_no_done",  32'(done_cnt - base_done), 0);
        chk("rst_no_error", 32'(err_cnt - base_err), 0);
        chk("rst_idle",     32'(bus.oBusy), 0);

        chk("no_clk_dat_overlap", 32'(overlap_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
